present_masked_round_ctrl: RTL and testbench

// - Two-share nibble-serial PRESENT-80 round engine that drives the masked S-box pipeline (ANF step1 -> step2 GHPC stages).
// - Holds the 64-bit shared state and adds round-key shares per nibble.
// - Issues one nibble per cycle into the pipeline and writes the pipeline results back in place.
// - Applies pLayer, iterates ROUNDS rounds, then performs the final key addition.

---
 rtl/present_masked_round_ctrl_if.sv | 13 +
 rtl/present_masked_round_ctrl.sv | 149 ++++++++++++++
 tb/tb_present_masked_round_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/present_masked_round_ctrl_if.sv
// S-box pipeline bus: the round controller is the master, the masked
// ANF step1/step2 pipeline is the slave.
interface present_masked_round_ctrl_if;
    logic [3:0] sb_in0;
    logic [3:0] sb_in1;
    logic       sb_vin;
    logic       sb_en;
    logic [3:0] sb_out0;
    logic [3:0] sb_out1;

    modport master (output sb_in0, sb_in1, sb_vin, sb_en, input sb_out0, sb_out1);
    modport slave  (input sb_in0, sb_in1, sb_vin, sb_en, output sb_out0, sb_out1);
endinterface

// File: rtl/present_masked_round_ctrl.sv
// Two-share nibble-serial PRESENT-80 round engine feeding an external masked
// S-box pipeline. Shares are processed by parallel, fully separate datapaths.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; ciphertext registers hold the last result
// SUB    | issue 16 nibbles (state^rk) and write pipeline results back
// PERM   | pLayer on both shares, advance round index
// FINAL  | final round-key addition, latch ciphertext
// DONE   | one-cycle done pulse
module present_masked_round_ctrl #(
    parameter int SBOX_LAT = 2,
    parameter int ROUNDS   = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] pt0,
    input  logic [63:0] pt1,
    input  logic [63:0] rk0,
    input  logic [63:0] rk1,
    output logic [4:0]  rnd_idx,
    present_masked_round_ctrl_if.master sb,
    output logic [63:0] ct0,
    output logic [63:0] ct1,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SUB   = 3'd1,
        S_PERM  = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [63:0]         st0;
    logic [63:0]         st1;
    logic [63:0]         perm0;
    logic [63:0]         perm1;
    logic [4:0]          rd_cnt;     // bit 4 set once all 16 nibbles are issued
    logic [3:0]          wr_idx;
    logic [SBOX_LAT-1:0] vld_sr;
    logic [SBOX_LAT:0]   vld_nxt;
    logic                issue;
    logic                wr_vld;

    assign issue   = (state == S_SUB) && !rd_cnt[4];
    assign vld_nxt = {vld_sr, issue};
    assign wr_vld  = vld_nxt[SBOX_LAT];

    // pLayer: bit i moves to 16*i mod 63, bit 63 stays; one copy per share
    always_comb begin
        perm0 = '0;
        perm1 = '0;
        for (int i = 0; i < 63; i++) begin
            perm0[(16 * i) % 63] = st0[i];
            perm1[(16 * i) % 63] = st1[i];
        end
        perm0[63] = st0[63];
        perm1[63] = st1[63];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SUB;
            S_SUB:   if (wr_vld && (wr_idx == 4'hF)) state_nxt = S_PERM;
            S_PERM:  state_nxt = (rnd_idx < LAST_RND) ? S_SUB : S_FINAL;
            S_FINAL: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: nibble issue, pipeline clock-gate enable, status flags
    always_comb begin
        sb.sb_vin = issue;
        sb.sb_in0 = '0;
        sb.sb_in1 = '0;
        if (issue) begin
            sb.sb_in0 = st0[{rd_cnt[3:0], 2'b00} +: 4] ^ rk0[{rd_cnt[3:0], 2'b00} +: 4];
            sb.sb_in1 = st1[{rd_cnt[3:0], 2'b00} +: 4] ^ rk1[{rd_cnt[3:0], 2'b00} +: 4];
        end
        sb.sb_en = issue | (|vld_sr);
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
    end

    // Share state, counters and ciphertext; writes trail reads by SBOX_LAT nibbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st0     <= '0;
            st1     <= '0;
            ct0     <= '0;
            ct1     <= '0;
            rnd_idx <= '0;
            rd_cnt  <= '0;
            wr_idx  <= '0;
            vld_sr  <= '0;
        end else begin
            vld_sr <= vld_nxt[SBOX_LAT-1:0];
            case (state)
                S_IDLE: begin
                    if (start) begin
                        st0     <= pt0;
                        st1     <= pt1;
                        rnd_idx <= '0;
                        rd_cnt  <= '0;
                        wr_idx  <= '0;
                    end
                end
                S_SUB: begin
                    if (!rd_cnt[4]) rd_cnt <= rd_cnt + 5'd1;
                    if (wr_vld) begin
                        st0[{wr_idx, 2'b00} +: 4] <= sb.sb_out0;
                        st1[{wr_idx, 2'b00} +: 4] <= sb.sb_out1;
                        wr_idx <= wr_idx + 4'd1;
                    end
                end
                S_PERM: begin
                    st0     <= perm0;
                    st1     <= perm1;
                    rnd_idx <= rnd_idx + 5'd1;
                    rd_cnt  <= '0;
                    wr_idx  <= '0;
                end
                S_FINAL: begin
                    st0 <= st0 ^ rk0;
                    st1 <= st1 ^ rk1;
                    ct0 <= st0 ^ rk0;
                    ct1 <= st1 ^ rk1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_present_masked_round_ctrl.sv
// Bench for present_masked_round_ctrl: masked S-box pipeline model, PRESENT-80
// reference model, table-driven encryptions plus reset / start-abuse sequences.
module tb_present_masked_round_ctrl;
    localparam int LAT     = 2;
    localparam int NRND    = 31;
    localparam int LATENCY = NRND * (LAT + 17) + 1;
    localparam int BUDGET  = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] pt0 = '0;
    logic [63:0] pt1 = '0;
    logic [63:0] rk0;
    logic [63:0] rk1;
    logic [4:0]  rnd_idx;
    logic [63:0] ct0;
    logic [63:0] ct1;
    logic        busy;
    logic        done;

    present_masked_round_ctrl_if sb_if ();

    present_masked_round_ctrl #(.SBOX_LAT(LAT), .ROUNDS(NRND)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pt0(pt0), .pt1(pt1), .rk0(rk0), .rk1(rk1),
        .rnd_idx(rnd_idx), .sb(sb_if),
        .ct0(ct0), .ct1(ct1), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] sb4(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h21748FE3DA09B65C;
        return t[4*x +: 4];
    endfunction

    function automatic logic [63:0] sbx(input logic [63:0] s);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = sb4(s[4*n +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] play(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[(i / 4) + 16 * (i % 4)] = s[i];
        return r;
    endfunction

    logic [63:0] rk_ref [32];
    logic [63:0] rs     [31];   // cipher state entering each round

    task automatic build_ref(input logic [63:0] pt, input logic [79:0] key, output logic [63:0] ct);
        logic [79:0] k;
        logic [63:0] s;
        k = key;
        for (int r = 0; r < 32; r++) begin
            rk_ref[r] = k[79:16];
            k = {k[18:0], k[79:19]};
            k[79:76] = sb4(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r + 1);
        end
        s = pt;
        for (int r = 0; r < 31; r++) begin
            rs[r] = s;
            s = play(sbx(s ^ rk_ref[r]));
        end
        ct = s ^ rk_ref[31];
    endtask

    // ---------------- share split ----------------
    logic [63:0] pm;
    logic [63:0] km      [32];
    logic [63:0] rk0_tab [32];
    logic [63:0] rk1_tab [32];

    assign rk0 = rk0_tab[rnd_idx];
    assign rk1 = rk1_tab[rnd_idx];

    // mode 0: share1 all zero; 1: fresh random masks; 2: previous masks inverted
    task automatic set_shares(input logic [63:0] pt, input int mode);
        if (mode == 0) pm = '0;
        else if (mode == 1) pm = {$urandom, $urandom};
        else pm = ~pm;
        for (int r = 0; r < 32; r++) begin
            if (mode == 0) km[r] = '0;
            else if (mode == 1) km[r] = {$urandom, $urandom};
            else km[r] = ~km[r];
            rk0_tab[r] = rk_ref[r] ^ km[r];
            rk1_tab[r] = km[r];
        end
        pt0 = pt ^ pm;
        pt1 = pm;
    endtask

    // ---------------- masked S-box pipeline model ----------------
    bit       pipe_v  [LAT];
    bit [3:0] pipe_o0 [LAT];
    bit [3:0] pipe_o1 [LAT];

    always @(posedge clk) begin
        logic       v;
        logic       rs_s;
        logic [3:0] i0;
        logic [3:0] i1;
        logic [3:0] m;
        v = sb_if.sb_vin; i0 = sb_if.sb_in0; i1 = sb_if.sb_in1; rs_s = rst_n;
        #1;
        for (int k = LAT - 1; k > 0; k--) begin
            pipe_v[k] = pipe_v[k-1]; pipe_o0[k] = pipe_o0[k-1]; pipe_o1[k] = pipe_o1[k-1];
        end
        m = 4'($urandom);
        pipe_v[0]  = v && rs_s;
        pipe_o0[0] = sb4(i0 ^ i1) ^ m;
        pipe_o1[0] = m;
        if (!rs_s) for (int k = 0; k < LAT; k++) pipe_v[k] = 1'b0;
        if (pipe_v[LAT-1]) begin
            sb_if.sb_out0 = pipe_o0[LAT-1];
            sb_if.sb_out1 = pipe_o1[LAT-1];
        end else begin
            sb_if.sb_out0 = 4'($urandom);   // junk with no valid must be ignored
            sb_if.sb_out1 = 4'($urandom);
        end
    end

    // ---------------- per-cycle monitor ----------------
    bit mon_en   = 1'b0;
    int vin_total = 0;
    int ord_err  = 0;
    int en_err   = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        logic        inflight;
        logic [63:0] x;
        int          r;
        int          n;
        if (done) done_cnt++;
        if (mon_en) begin
            inflight = 1'b0;
            for (int k = 0; k < LAT; k++) inflight |= pipe_v[k];
            if (sb_if.sb_vin) begin
                r = vin_total / 16;
                n = vin_total % 16;
                if (r > 30) ord_err++;
                else begin
                    x = rs[r] ^ rk_ref[r];
                    if ((sb_if.sb_in0 ^ sb_if.sb_in1) != x[4*n +: 4] || int'(rnd_idx) != r) ord_err++;
                end
                vin_total++;
            end
            if (sb_if.sb_en != (sb_if.sb_vin || inflight)) en_err++;
            if (!busy && (sb_if.sb_en || sb_if.sb_vin)) en_err++;
        end
    end

    // ---------------- one full encryption ----------------
    task automatic run_enc(input logic [63:0] pt, input logic [79:0] key, input logic [63:0] exp_ct,
                           input int mode, input bit noisy, input string nm);
        logic [63:0] dummy;
        logic [63:0] c0;
        logic [63:0] c1;
        int          cyc;
        int          dc0;
        build_ref(pt, key, dummy);
        set_shares(pt, mode);
        @(negedge clk);
        vin_total = 0; ord_err = 0; en_err = 0; dc0 = done_cnt; mon_en = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        if (!noisy) start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            if (noisy) begin
                pt0 = {$urandom, $urandom};
                pt1 = {$urandom, $urandom};
            end
        end
        check({nm, " done_seen"}, 64'(done), 64'd1);
        check({nm, " latency"}, 64'(cyc), 64'(LATENCY));
        check({nm, " ct"}, ct0 ^ ct1, exp_ct);
        check({nm, " rnd_idx_sat"}, 64'(rnd_idx), 64'(NRND));
        c0 = ct0; c1 = ct1;
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, " done_pulse"}, 64'(done), 64'd0);
        check({nm, " busy_after"}, 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check({nm, " ct_held"}, {c0 ^ ct0} | {c1 ^ ct1}, 64'd0);
        check({nm, " idle_busy"}, 64'(busy), 64'd0);
        check({nm, " done_count"}, 64'(done_cnt - dc0), 64'd1);
        check({nm, " vin_cycles"}, 64'(vin_total), 64'(NRND * 16));
        check({nm, " issue_order"}, 64'(ord_err), 64'd0);
        check({nm, " sb_en_gate"}, 64'(en_err), 64'd0);
        mon_en = 1'b0;
    endtask

    typedef struct {
        logic [63:0] pt;
        logic [79:0] key;
        logic [63:0] exp_ct;
        int          mode;
        bit          noisy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [63:0] e;
        logic [63:0] p;
        logic [79:0] k;

        vecs[0] = '{64'h0, 80'h0, 64'h5579C1387B228445, 0, 1'b0};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2, 1, 1'b0};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2, 2, 1'b0};
        for (int i = 3; i < 6; i++) begin
            p = {$urandom, $urandom};
            k = {16'($urandom), $urandom, $urandom};
            build_ref(p, k, e);
            vecs[i] = '{p, k, e, (i == 5) ? 2 : 1, (i == 3)};
        end
        for (int r = 0; r < 32; r++) begin
            rk0_tab[r] = '0;
            rk1_tab[r] = '0;
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst ct0", ct0, 64'd0);
        check("rst ct1", ct1, 64'd0);
        check("rst rnd_idx", 64'(rnd_idx), 64'd0);
        check("rst sb_vin", 64'(sb_if.sb_vin), 64'd0);
        check("rst sb_en", 64'(sb_if.sb_en), 64'd0);
        check("rst sb_in", 64'({sb_if.sb_in0, sb_if.sb_in1}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_enc(vecs[i].pt, vecs[i].key, vecs[i].exp_ct, vecs[i].mode, vecs[i].noisy,
                    $sformatf("vec%0d", i));

        // reset in the middle of an encryption, then a fresh start
        p = {$urandom, $urandom};
        k = {16'($urandom), $urandom, $urandom};
        build_ref(p, k, e);
        set_shares(p, 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst ct", ct0 | ct1, 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst rnd_idx", 64'(rnd_idx), 64'd0);
        check("midrst sb_en", 64'(sb_if.sb_en), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_enc(p, k, e, 1, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
